// File: rtl/risc_ifetch_32_pkg.sv
// Shared definitions for the 32-bit RISC-V instruction fetch unit:
// FSM encoding, the NOP instruction and the buffered fetch entry layout.
package risc_ifetch_32_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/risc_ifetch_32_if.sv
// Fetch-unit bus: PC block control, instruction memory request/response and
// decode handshake. master is the fetch unit, slave is its environment.
interface risc_ifetch_32_if;
  logic [31:0] pc_32;
  logic        pc_load;
  logic        flush;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr_32;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data_32;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr_32;
  logic [31:0] id_pc_32;

  modport master (
    input  pc_32, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data_32, id_ready,
    output pc_load, imem_req_valid, imem_req_addr_32, id_valid, id_instr_32, id_pc_32
  );

  modport slave (
    output pc_32, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data_32, id_ready,
    input  pc_load, imem_req_valid, imem_req_addr_32, id_valid, id_instr_32, id_pc_32
  );
endinterface

// File: rtl/risc_ifetch_32_fifo.sv
// Circular FIFO holding fetched {pc, instr} entries; flush empties it and
// overrides any same-cycle push or pop. DEPTH must be a power of two.
module risc_fifo_32 #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;

  // NOTE: every _d gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; reads are only meaningful while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Requests are only issued with room to spare, so a push never meets a full buffer.
  assert property (@(posedge clk) disable iff (reset) !(push_i && count_q == FULL_COUNT));

endmodule

// File: rtl/risc_ifetch_32.sv
// Instruction fetch unit: at most one imem request in flight, responses queued
// for decode, redirects (flush) drop in-flight and buffered instructions.
module risc_ifetch_32
  import risc_ifetch_32_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic              clk,
  input logic              reset,
  risc_ifetch_32_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_COUNT = CW'(DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   inflight_q, inflight_d;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          req_valid;
  logic          push;
  logic          pop;

  always_comb begin
    state_d    = state_q;
    inflight_d = inflight_q;
    req_valid  = 1'b0;
    push       = 1'b0;
    case (state_q)
      ST_REQ: begin
        req_valid = (count < DEPTH_COUNT) && !bus.flush && !reset;
        if (req_valid && bus.imem_req_ready) begin
          state_d    = ST_WAIT;
          inflight_d = bus.pc_32;
        end
      end
      ST_WAIT: begin
        if (bus.imem_rsp_valid) begin
          push    = !bus.flush;
          state_d = ST_REQ;
        end else if (bus.flush) begin
          state_d = ST_DROP;
        end
      end
      // The request issued before the redirect still owes a response; swallow it.
      ST_DROP: if (bus.imem_rsp_valid) state_d = ST_REQ;
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_REQ;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
    end
  end

  assign push_entry           = '{pc: inflight_q, instr: bus.imem_rsp_data_32};
  assign bus.imem_req_valid   = req_valid;
  assign bus.imem_req_addr_32 = bus.pc_32;
  assign bus.pc_load          = (req_valid && bus.imem_req_ready) || (bus.flush && !reset);
  assign bus.id_valid         = (count != '0) && !bus.flush && !reset;
  assign pop                  = bus.id_valid && bus.id_ready;

  // An empty buffer presents the reset PC with a NOP so decode never sees stale data.
  assign {bus.id_pc_32, bus.id_instr_32} = (count != '0) ? head : {RESET_PC, NOP_INSTR};

  risc_fifo_32 #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (bus.flush),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count)
  );

endmodule

// File: tb/tb_risc_ifetch_32.sv
// Self-checking bench for risc_ifetch_32: directed scenarios plus a randomized
// run against a queue-based model of the fetch/decode contract.
module tb_risc_ifetch_32;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_1000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  risc_ifetch_32_if bus();

  risc_ifetch_32 #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          errors   = 0;
  int          pc_loads = 0;
  logic [31:0] pc;
  logic [31:0] redirect_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic idle();
    bus.flush            = 1'b0;
    bus.imem_req_ready   = 1'b0;
    bus.imem_rsp_valid   = 1'b0;
    bus.imem_rsp_data_32 = 32'h0;
    bus.id_ready         = 1'b0;
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc = v;
    bus.pc_32 = v;
  endtask

  // Plays the PC block: loads the redirect target on flush, otherwise pc+4.
  task automatic step();
    logic load, fl;
    load = bus.pc_load;
    fl   = bus.flush;
    @(posedge clk);
    #1;
    if (load) begin
      pc = fl ? redirect_pc : pc + 32'd4;
      pc_loads++;
    end
    bus.pc_32 = pc;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    bus.flush = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.id_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); end
    checks++; if (bus.pc_load !== 1'b0) begin errors++; $display("FAIL reset_pc_load: got %b want 0", bus.pc_load); end
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b want 0", bus.id_valid); end
    checks++; if (bus.id_pc_32 !== RESET_PC) begin errors++; $display("FAIL reset_id_pc: got %h want %h", bus.id_pc_32, RESET_PC); end
    checks++; if (bus.id_instr_32 !== NOP) begin errors++; $display("FAIL reset_id_instr: got %h want %h", bus.id_instr_32, NOP); end
    step();
    idle();
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL post_reset_req_valid: got %b want 1", bus.imem_req_valid); end
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL post_reset_id_valid: got %b want 0", bus.id_valid); end
    checks++; if (bus.id_pc_32 !== RESET_PC) begin errors++; $display("FAIL post_reset_id_pc: got %h want %h", bus.id_pc_32, RESET_PC); end
    step();
  endtask

  task automatic test_basic_fetch();
    idle();
    set_pc(32'h0);
    pc_loads = 0;
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL basic_req_valid: got %b want 1", bus.imem_req_valid); end
    checks++; if (bus.imem_req_addr_32 !== 32'h0) begin errors++; $display("FAIL basic_req_addr: got %h want 0", bus.imem_req_addr_32); end
    checks++; if (bus.pc_load !== 1'b1) begin errors++; $display("FAIL basic_pc_load: got %b want 1", bus.pc_load); end
    step();
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL basic_wait_req_valid: got %b want 0", bus.imem_req_valid); end
    step();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data_32 = 32'h0050_0093;
    @(negedge clk);
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL basic_rsp_cycle_id_valid: got %b want 0", bus.id_valid); end
    step();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.id_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL basic_id_valid: got %b want 1", bus.id_valid); end
    checks++; if (bus.id_pc_32 !== 32'h0) begin errors++; $display("FAIL basic_id_pc: got %h want 0", bus.id_pc_32); end
    checks++; if (bus.id_instr_32 !== 32'h0050_0093) begin errors++; $display("FAIL basic_id_instr: got %h want 00500093", bus.id_instr_32); end
    step();
    bus.id_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL basic_after_pop_id_valid: got %b want 0", bus.id_valid); end
    checks++; if (pc_loads !== 1) begin errors++; $display("FAIL basic_pc_load_count: got %0d want 1", pc_loads); end
    step();
  endtask

  task automatic test_backpressure();
    logic        outstanding;
    logic [31:0] pending;
    int          pushes;
    int          loads_before;
    outstanding = 1'b0;
    pending = 32'h0;
    pushes = 0;
    idle();
    set_pc(32'h0);
    bus.imem_req_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.imem_rsp_valid = outstanding;
      bus.imem_rsp_data_32 = mem_word(pending);
      @(negedge clk);
      if (pushes == 2) begin
        checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_full_req_valid c%0d: got %b want 0", c, bus.imem_req_valid); end
        checks++; if (bus.pc_load !== 1'b0) begin errors++; $display("FAIL bp_full_pc_load c%0d: got %b want 0", c, bus.pc_load); end
      end
      if (outstanding) begin
        pushes++;
        outstanding = 1'b0;
      end else if (bus.imem_req_valid) begin
        outstanding = 1'b1;
        pending = pc;
      end
      step();
    end
    bus.imem_rsp_valid = 1'b0;
    bus.id_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL bp_pop_id_valid: got %b want 1", bus.id_valid); end
    checks++; if (bus.id_pc_32 !== 32'h0) begin errors++; $display("FAIL bp_pop_id_pc: got %h want 0", bus.id_pc_32); end
    step();
    bus.id_ready = 1'b0;
    loads_before = pc_loads;
    for (int c = 0; c < 6; c++) begin
      bus.imem_rsp_valid = outstanding;
      bus.imem_rsp_data_32 = mem_word(pending);
      @(negedge clk);
      if (outstanding) outstanding = 1'b0;
      else if (bus.imem_req_valid) begin
        outstanding = 1'b1;
        pending = pc;
      end
      step();
    end
    checks++; if (pc_loads - loads_before !== 1) begin errors++; $display("FAIL bp_resume_requests: got %0d want 1", pc_loads - loads_before); end
    idle();
    bus.id_ready = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      checks++; if (bus.id_valid !== 1'b1 || bus.id_pc_32 !== 32'(4 * k)) begin errors++; $display("FAIL bp_drain_pc%0d: got v=%b pc=%h want v=1 pc=%h", k, bus.id_valid, bus.id_pc_32, 32'(4 * k)); end
      checks++; if (bus.id_instr_32 !== mem_word(32'(4 * k))) begin errors++; $display("FAIL bp_drain_instr%0d: got %h want %h", k, bus.id_instr_32, mem_word(32'(4 * k))); end
      step();
    end
    bus.id_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL bp_drained_id_valid: got %b want 0", bus.id_valid); end
    step();
  endtask

  task automatic test_flush_wait();
    idle();
    set_pc(32'h20);
    redirect_pc = 32'h200;
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL fw_req_valid: got %b want 1", bus.imem_req_valid); end
    step();
    bus.flush = 1'b1;
    @(negedge clk);
    checks++; if (bus.pc_load !== 1'b1) begin errors++; $display("FAIL fw_flush_pc_load: got %b want 1", bus.pc_load); end
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL fw_flush_req_valid: got %b want 0", bus.imem_req_valid); end
    step();
    bus.flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data_32 = 32'h1234_5678;
      end
      @(negedge clk);
      checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL fw_drop_req_valid c%0d: got %b want 0", c, bus.imem_req_valid); end
      step();
    end
    bus.imem_rsp_valid = 1'b0;
    bus.imem_req_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL fw_resume_req_valid: got %b want 1", bus.imem_req_valid); end
    checks++; if (bus.imem_req_addr_32 !== 32'h200) begin errors++; $display("FAIL fw_resume_addr: got %h want 200", bus.imem_req_addr_32); end
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL fw_id_valid: got %b want 0", bus.id_valid); end
    step();
    @(negedge clk);
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL fw_dropped_id_valid: got %b want 0", bus.id_valid); end
    step();
  endtask

  task automatic test_flush_same_cycle();
    idle();
    set_pc(32'h40);
    redirect_pc = 32'h300;
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    step();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data_32 = mem_word(32'h40);
    @(negedge clk);
    step();
    bus.imem_rsp_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL fs_one_entry_id_valid: got %b want 1", bus.id_valid); end
    checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL fs_second_req_valid: got %b want 1", bus.imem_req_valid); end
    step();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data_32 = mem_word(32'h44);
    bus.flush = 1'b1;
    bus.id_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL fs_flush_cycle_id_valid: got %b want 0", bus.id_valid); end
    checks++; if (bus.pc_load !== 1'b1) begin errors++; $display("FAIL fs_flush_pc_load: got %b want 1", bus.pc_load); end
    step();
    idle();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL fs_cleared_id_valid c%0d: got %b want 0", c, bus.id_valid); end
      checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL fs_cleared_req_valid c%0d: got %b want 1", c, bus.imem_req_valid); end
      step();
    end
  endtask

  task automatic test_pointer_wrap();
    logic outstanding;
    int   accepted;
    int   popped;
    outstanding = 1'b0;
    accepted = 0;
    popped = 0;
    idle();
    set_pc(32'h0);
    bus.imem_req_ready = 1'b1;
    bus.id_ready = 1'b1;
    for (int c = 0; c < 40 && popped < 5; c++) begin
      bus.imem_req_ready = (accepted < 5);
      bus.imem_rsp_valid = outstanding;
      bus.imem_rsp_data_32 = mem_word(pc - 32'd4);
      @(negedge clk);
      if (bus.id_valid) begin
        checks++; if (bus.id_pc_32 !== 32'(4 * popped)) begin errors++; $display("FAIL wrap_pc%0d: got %h want %h", popped, bus.id_pc_32, 32'(4 * popped)); end
        checks++; if (bus.id_instr_32 !== mem_word(32'(4 * popped))) begin errors++; $display("FAIL wrap_instr%0d: got %h want %h", popped, bus.id_instr_32, mem_word(32'(4 * popped))); end
        popped++;
      end
      if (outstanding) outstanding = 1'b0;
      else if (bus.imem_req_valid && bus.imem_req_ready) begin
        outstanding = 1'b1;
        accepted++;
      end
      step();
    end
    checks++; if (popped !== 5) begin errors++; $display("FAIL wrap_count: got %0d want 5", popped); end
    idle();
  endtask

  task automatic test_reset_in_wait();
    idle();
    set_pc(32'h80);
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    step();
    bus.imem_req_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b0 || bus.pc_load !== 1'b0 || bus.id_valid !== 1'b0) begin errors++; $display("FAIL rw_reset_outputs: got rv=%b ld=%b idv=%b want 0 0 0", bus.imem_req_valid, bus.pc_load, bus.id_valid); end
    step();
    reset = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data_32 = 32'hBAD0_0BAD;
    @(negedge clk);
    checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL rw_stale_req_valid: got %b want 1", bus.imem_req_valid); end
    checks++; if (bus.id_pc_32 !== RESET_PC || bus.id_instr_32 !== NOP) begin errors++; $display("FAIL rw_reset_head: got %h/%h want %h/%h", bus.id_pc_32, bus.id_instr_32, RESET_PC, NOP); end
    step();
    bus.imem_rsp_valid = 1'b0;
    set_pc(32'hC0);
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rw_stale_ignored: got %b want 0", bus.id_valid); end
    checks++; if (bus.imem_req_addr_32 !== 32'hC0 || bus.pc_load !== 1'b1) begin errors++; $display("FAIL rw_next_fetch: got addr=%h ld=%b want C0 1", bus.imem_req_addr_32, bus.pc_load); end
    step();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data_32 = mem_word(32'hC0);
    @(negedge clk);
    step();
    bus.imem_rsp_valid = 1'b0;
    bus.id_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.id_valid !== 1'b1 || bus.id_pc_32 !== 32'hC0 || bus.id_instr_32 !== mem_word(32'hC0)) begin errors++; $display("FAIL rw_fetch_result: got v=%b pc=%h instr=%h want 1 C0 %h", bus.id_valid, bus.id_pc_32, bus.id_instr_32, mem_word(32'hC0)); end
    step();
    idle();
  endtask

  task automatic test_random();
    ent_t        q[$];
    logic        outstanding;
    logic        dropped;
    logic [31:0] pend_pc;
    logic        rsp, exp_rv, exp_load, exp_idv;
    outstanding = 1'b0;
    dropped = 1'b0;
    pend_pc = 32'h0;
    idle();
    set_pc(32'h100);
    for (int c = 0; c < 600; c++) begin
      bus.flush = ($urandom_range(15) == 0);
      redirect_pc = {$urandom_range(32'h3FFF), 2'b00};
      bus.imem_req_ready = ($urandom_range(3) != 0);
      bus.id_ready = ($urandom_range(2) != 0);
      rsp = outstanding ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      bus.imem_rsp_valid = rsp;
      bus.imem_rsp_data_32 = $urandom;
      @(negedge clk);
      exp_rv   = !outstanding && (q.size() < DEPTH) && !bus.flush;
      exp_load = (exp_rv && bus.imem_req_ready) || bus.flush;
      exp_idv  = (q.size() != 0) && !bus.flush;
      checks++; if (bus.imem_req_valid !== exp_rv) begin errors++; $display("FAIL rnd_req_valid c%0d: got %b want %b", c, bus.imem_req_valid, exp_rv); end
      checks++; if (bus.pc_load !== exp_load) begin errors++; $display("FAIL rnd_pc_load c%0d: got %b want %b", c, bus.pc_load, exp_load); end
      checks++; if (bus.id_valid !== exp_idv) begin errors++; $display("FAIL rnd_id_valid c%0d: got %b want %b", c, bus.id_valid, exp_idv); end
      if (exp_rv) begin
        checks++; if (bus.imem_req_addr_32 !== pc) begin errors++; $display("FAIL rnd_req_addr c%0d: got %h want %h", c, bus.imem_req_addr_32, pc); end
      end
      if (exp_idv) begin
        checks++; if (bus.id_pc_32 !== q[0].pc || bus.id_instr_32 !== q[0].instr) begin errors++; $display("FAIL rnd_head c%0d: got %h/%h want %h/%h", c, bus.id_pc_32, bus.id_instr_32, q[0].pc, q[0].instr); end
      end
      if (exp_idv && bus.id_ready) void'(q.pop_front());
      if (rsp && outstanding) begin
        if (!bus.flush && !dropped) q.push_back('{pc: pend_pc, instr: bus.imem_rsp_data_32});
        outstanding = 1'b0;
      end else if (bus.flush && outstanding) begin
        dropped = 1'b1;
      end
      if (bus.flush) q.delete();
      if (exp_rv && bus.imem_req_ready) begin
        outstanding = 1'b1;
        dropped = 1'b0;
        pend_pc = pc;
      end
      step();
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    redirect_pc = 32'h0;
    idle();
    set_pc(32'h0);
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_flush_wait();
    test_flush_same_cycle();
    test_pointer_wrap();
    test_reset_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
